alu_op_stage: RTL and testbench
===============================

Name: alu_op_stage

Overview:
- Pipeline stage directly upstream of the 32-bit combinational ALU; also captures the ALU's outputs.
- Accepts one operation per valid/ready handshake: operand A, operand B, 3-bit command and a tag.
- Drives the ALU from stable registers for one full cycle, then registers result and flags into a valid/ready output slot for the writeback/consumer stage.
- Isolates the ALU's long carry path between two register boundaries.

Parameters:
- TAG_W, 4, width of the pass-through operation tag.

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  upstream operation valid
- in_ready  out  1  stage can accept an operation this cycle
- in_a  in  32  operand A
- in_b  in  32  operand B
- in_cmd  in  3  ALU command: 0 ADD, 1 SUB, 2 XOR, 3 SLT, 4 AND, 5 NAND, 6 NOR, 7 OR
- in_tag  in  TAG_W  opaque tag, returned with the result
- alu_a  out  32  registered operand A to ALU
- alu_b  out  32  registered operand B to ALU
- alu_cmd  out  3  registered command to ALU
- alu_result  in  32  ALU result
- alu_carryout  in  1  ALU carry flag
- alu_zero  in  1  ALU zero flag
- alu_overflow  in  1  ALU overflow flag
- out_valid  out  1  registered result valid
- out_ready  in  1  downstream accepts result
- out_result  out  32  captured result
- out_carryout  out  1  captured carry
- out_zero  out  1  captured zero
- out_overflow  out  1  captured overflow
- out_cmd  out  3  command that produced the result
- out_tag  out  TAG_W  tag of the operation

Behaviour:
- Reset: state IDLE. All outputs are 0: alu_a, alu_b, alu_cmd, out_* and out_valid. in_ready is 0 while reset is high.
- Reset mid-operation discards the in-flight operation and any unconsumed result. No output handshake occurs for it.
- State IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid: load in_a/in_b/in_cmd/in_tag into alu_a/alu_b/alu_cmd and the tag register, then go to EXEC.
- State EXEC (exactly 1 cycle):
  - in_ready=0, out_valid=0. alu_* are held constant.
  - At the clock edge, capture alu_result and the three flags into the out_* registers. Copy alu_cmd to out_cmd and the tag register to out_tag. Go to DONE.
- State DONE:
  - out_valid=1. All out_* are held stable while out_ready=0.
  - in_ready = out_ready (combinational pass-through).
  - out_ready=1 and in_valid=1: result consumed, new operation loaded into alu_*, go to EXEC (no bubble cycle).
  - out_ready=1 and in_valid=0: go to IDLE. out_valid falls next cycle; out_* hold their last values.
  - out_ready=0: stay in DONE. in_valid is ignored.
- Latency and throughput:
  - Accept edge to out_valid=1 is 2 clock edges.
  - Maximum throughput is one operation per 2 cycles.
- Flags are captured unmodified. The ALU reports carry/zero/overflow only for ADD/SUB, so the stage must not recompute or mask them. For XOR..OR and SLT the out_* flags are 0.
- alu_* must change only on an accept edge, never in EXEC or DONE, so the ALU inputs are stable for the whole EXEC cycle.
- in_cmd is 3 bits, so every encoding is legal. Operand arithmetic is 32-bit two's complement inside the ALU; the stage does none.
- No combinational path from in_* to out_*. The only combinational input-to-output path is out_ready -> in_ready.

Optional Feature:
- Macro ALU_STICKY_FLAGS_EN.
- When defined, add ports sticky_clr (in, 1) and sticky_flags (out, 3, {overflow, carryout, zero}).
  - On each EXEC->DONE capture, sticky_flags |= captured flags.
  - sticky_clr=1 clears sticky_flags to 0. If clear and capture occur in the same cycle, the result equals the newly captured flags only.
  - Reset value is 0.
- When not defined, the ports and the register do not exist; all other behaviour is identical.

Test Plan:
- ADD 0x7FFFFFFF + 0x00000001, tag 0x3 -> out_valid 2 edges after accept; result 0x80000000, overflow 1, carry 0, zero 0, tag 0x3, cmd 0.
- SUB 0x00000005 - 0x00000005 -> result 0x00000000, zero 1, carryout 1, overflow 0.
- SLT 0xFFFFFFFF vs 0x00000001 -> result 0x00000001, all flags 0. Then XOR 0xF0F0F0F0 ^ 0xFFFFFFFF -> 0x0F0F0F0F, flags 0.
- Back-pressure: hold out_ready=0 for 5 cycles after out_valid -> out_* stable and in_ready=0 throughout. Then out_ready=1 with in_valid=1 (AND 0xFF00FF00 & 0x0FF00FF0) -> accepted that cycle; next out_valid gives 0x0F000F00 with the new tag.
- Assert reset during EXEC -> next cycle out_valid=0, all out_* 0, alu_* 0. After reset deasserts, in_ready=1 and no stale result appears.
- With ALU_STICKY_FLAGS_EN defined:
  - ADD overflow case, then SUB 5-5 -> sticky_flags 3'b111 (overflow 1, carry 1, zero 1).
  - Pulse sticky_clr -> 3'b000.
  - sticky_clr on a capture edge of ADD 1+1 -> 3'b000.

Source files
------------

// File: rtl/alu_op_stage.sv
// alu_op_stage: registered operand/command stage feeding a combinational ALU, plus a valid/ready result slot.
// Optional build macro ALU_STICKY_FLAGS_EN adds sticky_clr / sticky_flags accumulation of captured flags.
`default_nettype none

module alu_op_stage #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
`ifdef ALU_STICKY_FLAGS_EN
  input  logic             sticky_clr,
  output logic [2:0]       sticky_flags,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [2:0]       in_cmd,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [2:0]       alu_cmd,
  input  logic [31:0]      alu_result,
  input  logic             alu_carryout,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic             out_carryout,
  output logic             out_zero,
  output logic             out_overflow,
  output logic [2:0]       out_cmd,
  output logic [TAG_W-1:0] out_tag
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [31:0]      alu_a_q, alu_b_q, res_q;
  logic [2:0]       alu_cmd_q, out_cmd_q;
  logic [TAG_W-1:0] tag_q, out_tag_q;
  logic             carry_q, zero_q, ovf_q;
  logic             accept;
  logic             capture;

  always_comb begin
    in_ready = 1'b0;
    state_d  = state_q;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = S_EXEC;
      end
      S_EXEC: state_d = S_DONE;
      S_DONE: begin
        // Result slot frees in the same cycle it is consumed, so a new op can enter without a bubble.
        in_ready = out_ready;
        if (out_ready) state_d = in_valid ? S_EXEC : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (reset) in_ready = 1'b0;
  end

  assign accept  = in_valid & in_ready;
  assign capture = (state_q == S_EXEC);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_cmd_q <= '0;
      tag_q     <= '0;
      res_q     <= '0;
      carry_q   <= 1'b0;
      zero_q    <= 1'b0;
      ovf_q     <= 1'b0;
      out_cmd_q <= '0;
      out_tag_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        alu_a_q   <= in_a;
        alu_b_q   <= in_b;
        alu_cmd_q <= in_cmd;
        tag_q     <= in_tag;
      end
      if (capture) begin
        res_q     <= alu_result;
        carry_q   <= alu_carryout;
        zero_q    <= alu_zero;
        ovf_q     <= alu_overflow;
        out_cmd_q <= alu_cmd_q;
        out_tag_q <= tag_q;
      end
    end
  end

`ifdef ALU_STICKY_FLAGS_EN
  logic [2:0] sticky_q;

  // A clear coinciding with a capture keeps only the freshly captured flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      sticky_q <= '0;
    end else if (capture) begin
      sticky_q <= (sticky_clr ? 3'b000 : sticky_q) | {alu_overflow, alu_carryout, alu_zero};
    end else if (sticky_clr) begin
      sticky_q <= '0;
    end
  end

  assign sticky_flags = sticky_q;
`endif

  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_cmd      = alu_cmd_q;
  assign out_valid    = (state_q == S_DONE);
  assign out_result   = res_q;
  assign out_carryout = carry_q;
  assign out_zero     = zero_q;
  assign out_overflow = ovf_q;
  assign out_cmd      = out_cmd_q;
  assign out_tag      = out_tag_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_op_stage.sv
// Bench for alu_op_stage: behavioural ALU on the alu_* side, scoreboard of expected results on the output side.
`default_nettype none

module tb_alu_op_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [31:0] in_a, in_b;
  logic [2:0]  in_cmd;
  logic [3:0]  in_tag;
  logic [31:0] alu_a, alu_b;
  logic [2:0]  alu_cmd;
  logic [31:0] alu_result;
  logic        alu_carryout, alu_zero, alu_overflow;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic        out_carryout, out_zero, out_overflow;
  logic [2:0]  out_cmd;
  logic [3:0]  out_tag;
`ifdef ALU_STICKY_FLAGS_EN
  logic        sticky_clr;
  logic [2:0]  sticky_flags;
`endif

  typedef struct {
    logic [31:0] res;
    logic        c, z, v;
    logic [2:0]  cmd;
    logic [3:0]  tag;
  } exp_t;

  exp_t sb[$];
  exp_t nxt;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  alu_op_stage #(.TAG_W(4)) dut (
    .clk(clk), .reset(reset),
`ifdef ALU_STICKY_FLAGS_EN
    .sticky_clr(sticky_clr), .sticky_flags(sticky_flags),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_cmd(in_cmd), .in_tag(in_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cmd(alu_cmd),
    .alu_result(alu_result), .alu_carryout(alu_carryout),
    .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_carryout(out_carryout), .out_zero(out_zero), .out_overflow(out_overflow),
    .out_cmd(out_cmd), .out_tag(out_tag)
  );

  // Reference ALU: flags only for ADD/SUB, carry on SUB means "no borrow".
  function automatic exp_t alu_model(input logic [31:0] a, b, input logic [2:0] cmd, input logic [3:0] tag);
    exp_t        e;
    logic [32:0] s;
    e.c = 1'b0; e.z = 1'b0; e.v = 1'b0; e.cmd = cmd; e.tag = tag; e.res = '0;
    case (cmd)
      3'd0: begin
        s = {1'b0, a} + {1'b0, b};
        e.res = s[31:0]; e.c = s[32]; e.z = (s[31:0] == 0);
        e.v = (a[31] == b[31]) && (s[31] != a[31]);
      end
      3'd1: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        e.res = s[31:0]; e.c = s[32]; e.z = (s[31:0] == 0);
        e.v = (a[31] != b[31]) && (s[31] != a[31]);
      end
      3'd2: e.res = a ^ b;
      3'd3: e.res = {31'd0, $signed(a) < $signed(b)};
      3'd4: e.res = a & b;
      3'd5: e.res = ~(a & b);
      3'd6: e.res = ~(a | b);
      default: e.res = a | b;
    endcase
    return e;
  endfunction

  always_comb begin
    exp_t r;
    r = alu_model(alu_a, alu_b, alu_cmd, 4'd0);
    alu_result   = r.res;
    alu_carryout = r.c;
    alu_zero     = r.z;
    alu_overflow = r.v;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] res, input logic c, z, v, input logic [2:0] cmd, input logic [3:0] tag);
    exp_t e;
    e.res = res; e.c = c; e.z = z; e.v = v; e.cmd = cmd; e.tag = tag;
    return e;
  endfunction

  // Evaluate both handshakes for the coming edge, then advance to the next falling edge.
  task automatic tick();
    exp_t e;
    #1;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", 64'(out_valid), 64'd0);
      end else begin
        e = sb.pop_front();
        chk("out_result", 64'(out_result), 64'(e.res));
        chk("out_flags", 64'({out_carryout, out_zero, out_overflow}), 64'({e.c, e.z, e.v}));
        chk("out_cmd_tag", 64'({out_cmd, out_tag}), 64'({e.cmd, e.tag}));
      end
    end
    if (in_valid && in_ready) sb.push_back(nxt);
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && sb.size() != 0; i++) tick();
    chk("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  task automatic run_op(input logic [31:0] a, b, input logic [2:0] cmd, input logic [3:0] tag, input exp_t e);
    in_a = a; in_b = b; in_cmd = cmd; in_tag = tag; in_valid = 1'b1; nxt = e;
    tick();
    in_valid = 1'b0;
    chk("lat_edge1", 64'(out_valid), 64'd0);
    tick();
    chk("lat_edge2", 64'(out_valid), 64'd1);
    drain();
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cmd = '0; in_tag = '0; out_ready = 1'b1;
`ifdef ALU_STICKY_FLAGS_EN
    sticky_clr = 1'b0;
`endif
    @(negedge clk); @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_alu", 64'({alu_a, alu_cmd}), 64'd0);
    chk("rst_out", 64'({out_result, out_carryout, out_zero, out_overflow, out_cmd, out_tag}), 64'd0);
    reset = 1'b0;
    #1 chk("idle_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);

    run_op(32'h7FFFFFFF, 32'h00000001, 3'd0, 4'h3, mk(32'h80000000, 1'b0, 1'b0, 1'b1, 3'd0, 4'h3));
    run_op(32'h00000005, 32'h00000005, 3'd1, 4'h4, mk(32'h00000000, 1'b1, 1'b1, 1'b0, 3'd1, 4'h4));
    run_op(32'hFFFFFFFF, 32'h00000001, 3'd3, 4'h5, mk(32'h00000001, 1'b0, 1'b0, 1'b0, 3'd3, 4'h5));
    run_op(32'hF0F0F0F0, 32'hFFFFFFFF, 3'd2, 4'h6, mk(32'h0F0F0F0F, 1'b0, 1'b0, 1'b0, 3'd2, 4'h6));

    // Back-pressure: result held and a competing request ignored for five cycles.
    out_ready = 1'b0;
    in_a = 32'h12345678; in_b = 32'h0000FFFF; in_cmd = 3'd7; in_tag = 4'h7; in_valid = 1'b1;
    nxt = mk(32'h1234FFFF, 1'b0, 1'b0, 1'b0, 3'd7, 4'h7);
    tick();
    in_a = 32'hDEADBEEF; in_cmd = 3'd0; in_tag = 4'hE;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_hold", 64'({out_valid, out_result, out_tag}), 64'({1'b1, 32'h1234FFFF, 4'h7}));
      chk("bp_alu_hold", 64'(alu_a), 64'h12345678);
      tick();
    end
    out_ready = 1'b1;
    in_a = 32'hFF00FF00; in_b = 32'h0FF00FF0; in_cmd = 3'd4; in_tag = 4'h9;
    nxt = mk(32'h0F000F00, 1'b0, 1'b0, 1'b0, 3'd4, 4'h9);
    #1 chk("bp_release_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    chk("no_bubble_alu", 64'({alu_a, alu_cmd}), 64'({32'hFF00FF00, 3'd4}));
    drain();

    // Reset while EXEC: in-flight op must vanish.
    in_a = 32'd1; in_b = 32'd2; in_cmd = 3'd0; in_tag = 4'hA; in_valid = 1'b1;
    nxt = mk(32'd3, 1'b0, 1'b0, 1'b0, 3'd0, 4'hA);
    tick();
    in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("rstx_out_valid", 64'(out_valid), 64'd0);
    chk("rstx_out", 64'({out_result, out_carryout, out_zero, out_overflow, out_cmd, out_tag}), 64'd0);
    chk("rstx_alu", 64'({alu_a, alu_cmd}), 64'd0);
    sb.delete();
    reset = 1'b0;
    #1 chk("rstx_in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rstx_no_stale", 64'(out_valid), 64'd0);
    end

    for (int i = 0; i < 8; i++) begin
      logic [31:0] a, b;
      logic [2:0]  c;
      a = $urandom; b = (i == 0) ? a : $urandom; c = 3'(i);
      run_op(a, b, c, 4'(i + 1), alu_model(a, b, c, 4'(i + 1)));
    end

`ifdef ALU_STICKY_FLAGS_EN
    sticky_clr = 1'b1; tick(); sticky_clr = 1'b0;
    run_op(32'h7FFFFFFF, 32'h00000001, 3'd0, 4'h1, mk(32'h80000000, 1'b0, 1'b0, 1'b1, 3'd0, 4'h1));
    run_op(32'h00000005, 32'h00000005, 3'd1, 4'h2, mk(32'h00000000, 1'b1, 1'b1, 1'b0, 3'd1, 4'h2));
    chk("sticky_accum", 64'(sticky_flags), 64'h7);
    sticky_clr = 1'b1; tick(); sticky_clr = 1'b0;
    chk("sticky_clear", 64'(sticky_flags), 64'h0);
    run_op(32'h7FFFFFFF, 32'h00000001, 3'd0, 4'h3, mk(32'h80000000, 1'b0, 1'b0, 1'b1, 3'd0, 4'h3));
    chk("sticky_ovf", 64'(sticky_flags), 64'h4);
    in_a = 32'd1; in_b = 32'd1; in_cmd = 3'd0; in_tag = 4'h4; in_valid = 1'b1;
    nxt = mk(32'd2, 1'b0, 1'b0, 1'b0, 3'd0, 4'h4);
    tick();
    in_valid = 1'b0; sticky_clr = 1'b1;
    tick();
    sticky_clr = 1'b0;
    chk("sticky_clr_capture", 64'(sticky_flags), 64'h0);
    drain();
`endif

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
